mod_updown_counter: RTL and testbench

Parametrised loadable up/down modulo counter. It generalises the plain N-bit loadable counter with:

- a programmable modulus,
- direction control,
- count enable with prescaler,
- terminal-count lookahead and a wrap pulse,
- optional saturation mode.

It is used as the common timing/event counter in the counters library, wherever a block needs a loadable, bounded count.

---
 rtl/mod_counter_pkg.sv | 23 ++
 rtl/mod_updown_counter_en_prescaler.sv | 42 ++++
 rtl/mod_updown_counter.sv | 89 ++++++++
 tb/tb_mod_updown_counter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mod_counter_pkg.sv
// Shared types, defaults and helpers for the counters library.
// Imported by mod_updown_counter and en_prescaler.
package mod_counter_pkg;

   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } dir_t;

   localparam int DEF_N        = 4;
   localparam int DEF_PRESCALE = 1;

   // Ceiling log2, usable in parameter expressions.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/mod_updown_counter_en_prescaler.sv
// en_prescaler: divides qualified enable cycles by PRESCALE and flags the
// cycle on which the owning counter should step. clr restarts the phase.
module en_prescaler
   import mod_counter_pkg::*;
#(
   parameter int PRESCALE = DEF_PRESCALE
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic step_due
);

   // A 1-bit phase register is kept even for PRESCALE=1, where it stays at 0.
   localparam int            PW   = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] phase_q;
   logic [PW-1:0] phase_d;
   logic          at_last;

   always_comb begin
      at_last  = (phase_q == LAST);
      step_due = en & ~clr & at_last;
      phase_d  = phase_q;
      if (clr) begin
         phase_d = '0;
      end else if (en) begin
         phase_d = at_last ? '0 : phase_q + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         phase_q <= '0;
      end else begin
         phase_q <= phase_d;
      end
   end

endmodule

// File: rtl/mod_updown_counter.sv
// Loadable up/down modulo counter with prescaled enable, tc lookahead and wrap
// pulse. Define MOD_UPDOWN_COUNTER_SAT_EN to add the sat port (saturate mode).
module mod_updown_counter
   import mod_counter_pkg::*;
#(
   parameter int N        = DEF_N,
   parameter int MODULUS  = 2**N,
   parameter int PRESCALE = DEF_PRESCALE,
   parameter int RST_VAL  = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         load,
   input  logic [N-1:0] data,
   input  logic         up,
`ifdef MOD_UPDOWN_COUNTER_SAT_EN
   input  logic         sat,
`endif
   output logic [N-1:0] count,
   output logic         tc,
   output logic         wrap
);

   // Bounds are held in N+1 bits so that MODULUS = 2**N is representable.
   localparam logic [N:0]   MOD_W = (N+1)'(MODULUS);
   localparam logic [N:0]   MAX_W = (N+1)'(MODULUS - 1);
   localparam logic [N-1:0] MAX_N = MAX_W[N-1:0];
   localparam logic [N-1:0] RST_N = N'(RST_VAL);

   logic [N-1:0] count_q;
   logic [N-1:0] count_d;
   logic         wrap_q;
   logic         wrap_d;
   logic         step_due;
   logic         at_bound;
   logic [N-1:0] wrap_val;
   dir_t         dir;

   en_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .clr      (load),
      .step_due (step_due)
   );

   always_comb begin
      dir      = dir_t'(up);
      at_bound = (dir == DIR_UP) ? ({1'b0, count_q} == MAX_W) : (count_q == '0);
      wrap_val = (dir == DIR_UP) ? '0 : MAX_N;
      tc       = step_due & at_bound;
      count_d  = count_q;
      wrap_d   = 1'b0;
      if (load) begin
         count_d = ({1'b0, data} >= MOD_W) ? MAX_N : data;
      end else if (step_due) begin
         if (at_bound) begin
`ifdef MOD_UPDOWN_COUNTER_SAT_EN
            if (!sat) begin
               count_d = wrap_val;
               wrap_d  = 1'b1;
            end
`else
            count_d = wrap_val;
            wrap_d  = 1'b1;
`endif
         end else begin
            count_d = (dir == DIR_UP) ? count_q + N'(1) : count_q - N'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         count_q <= RST_N;
         wrap_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         wrap_q  <= wrap_d;
      end
   end

   assign count = count_q;
   assign wrap  = wrap_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: two instances (PRESCALE 1 and 3, MODULUS 10)
// share stimulus and are compared each cycle against an arithmetic model.
`timescale 1ns/1ps
module tb_mod_updown_counter;

   localparam int N   = 4;
   localparam int MOD = 10;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         en = 1'b0;
   logic         load = 1'b0;
   logic         up = 1'b1;
   logic         sat = 1'b0;
   logic [N-1:0] data = '0;

   logic [N-1:0] count1, count3;
   logic         tc1, tc3, wrap1, wrap3;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   // Model state, index 0 = PRESCALE 1, index 1 = PRESCALE 3.
   int m_cnt[2];
   int m_ph[2];
   int m_wrap[2];
   bit m_valid = 1'b0;

   always #5 clk = ~clk;

   mod_updown_counter #(.N(N), .MODULUS(MOD), .PRESCALE(1), .RST_VAL(0)) u_dut1 (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .load  (load),
      .data  (data),
      .up    (up),
`ifdef MOD_UPDOWN_COUNTER_SAT_EN
      .sat   (sat),
`endif
      .count (count1),
      .tc    (tc1),
      .wrap  (wrap1)
   );

   mod_updown_counter #(.N(N), .MODULUS(MOD), .PRESCALE(3), .RST_VAL(0)) u_dut3 (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .load  (load),
      .data  (data),
      .up    (up),
`ifdef MOD_UPDOWN_COUNTER_SAT_EN
      .sat   (sat),
`endif
      .count (count3),
      .tc    (tc3),
      .wrap  (wrap3)
   );

   function automatic int pres(input int i);
      return (i == 0) ? 1 : 3;
   endfunction

   function automatic bit sat_eff();
`ifdef MOD_UPDOWN_COUNTER_SAT_EN
      return sat;
`else
      return 1'b0;
`endif
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s (cycle %0d): got %0d, expected %0d", tag, cyc, obs, exp);
      end
   endtask

   function automatic int exp_tc(input int i);
      bit bound;
      bound = up ? (m_cnt[i] == MOD - 1) : (m_cnt[i] == 0);
      return (en && !load && m_ph[i] == pres(i) - 1 && bound) ? 1 : 0;
   endfunction

   task automatic model_edge();
      int nxt;
      bit crossing;
      for (int i = 0; i < 2; i++) begin
         m_wrap[i] = 0;
         if (!rst) begin
            m_cnt[i] = 0;
            m_ph[i]  = 0;
         end else if (load) begin
            m_cnt[i] = (int'(data) >= MOD) ? MOD - 1 : int'(data);
            m_ph[i]  = 0;
         end else if (en) begin
            if (m_ph[i] == pres(i) - 1) begin
               m_ph[i]  = 0;
               nxt      = (m_cnt[i] + (up ? 1 : MOD - 1)) % MOD;
               crossing = up ? (m_cnt[i] == MOD - 1) : (m_cnt[i] == 0);
               if (crossing && sat_eff()) nxt = m_cnt[i];
               m_wrap[i] = (crossing && !sat_eff()) ? 1 : 0;
               m_cnt[i]  = nxt;
            end else begin
               m_ph[i] = m_ph[i] + 1;
            end
         end
      end
      if (!rst) m_valid = 1'b1;
   endtask

   // One clock with the currently driven inputs: tc before the edge,
   // count and wrap just after it.
   task automatic cycle();
      #1;
      if (m_valid) begin
         check_eq("tc_p1", 32'(tc1), 32'(exp_tc(0)));
         check_eq("tc_p3", 32'(tc3), 32'(exp_tc(1)));
      end
      @(posedge clk);
      model_edge();
      #1;
      cyc++;
      check_eq("count_p1", 32'(count1), 32'(m_cnt[0]));
      check_eq("wrap_p1",  32'(wrap1),  32'(m_wrap[0]));
      check_eq("count_p3", 32'(count3), 32'(m_cnt[1]));
      check_eq("wrap_p3",  32'(wrap3),  32'(m_wrap[1]));
      $display("cyc %0d rst=%b ld=%b en=%b up=%b sat=%b d=%0d | p1 cnt=%0d tc=%b wrap=%b | p3 cnt=%0d tc=%b wrap=%b",
               cyc, rst, load, en, up, sat, data, count1, tc1, wrap1, count3, tc3, wrap3);
   endtask

   task automatic drive(input bit r, input bit l, input bit e, input bit u, input int d, input int n);
      rst  = r;
      load = l;
      en   = e;
      up   = u;
      data = N'(d);
      for (int k = 0; k < n; k++) cycle();
   endtask

   initial begin
      @(posedge clk);
      #1;
      // Reset dominates load and enable
      drive(0, 1, 1, 1, 7, 2);
      drive(1, 0, 1, 1, 0, 3);
      // Load and clamp
      drive(1, 1, 0, 1, 7, 1);
      drive(1, 1, 0, 1, 12, 1);
      drive(1, 1, 1, 1, 3, 1);
      drive(1, 1, 1, 1, 9, 1);
      drive(1, 1, 1, 1, 4, 1);
      // Up wrap
      drive(1, 1, 0, 1, 8, 1);
      drive(1, 0, 1, 1, 0, 3);
      // Down wrap
      drive(1, 1, 0, 0, 1, 1);
      drive(1, 0, 1, 0, 0, 3);
      // Prescale with a two-cycle enable gap mid-phase
      drive(1, 1, 0, 1, 0, 1);
      drive(1, 0, 1, 1, 0, 7);
      drive(1, 0, 0, 1, 0, 2);
      drive(1, 0, 1, 1, 0, 5);
      // Up wrap on the prescaled instance, then direction change
      drive(1, 1, 0, 1, 9, 1);
      drive(1, 0, 1, 1, 0, 4);
      drive(1, 0, 1, 0, 0, 4);
`ifdef MOD_UPDOWN_COUNTER_SAT_EN
      sat = 1'b1;
      drive(1, 1, 0, 1, 9, 1);
      drive(1, 0, 1, 1, 0, 3);
      drive(1, 0, 1, 0, 0, 2);
      drive(1, 1, 0, 0, 0, 1);
      drive(1, 0, 1, 0, 0, 3);
      sat = 1'b0;
`endif
      // Randomised traffic
      for (int t = 0; t < 400; t++) begin
         sat = 1'($urandom_range(0, 1));
         drive(($urandom_range(0, 49) != 0),
               ($urandom_range(0, 9) == 0),
               ($urandom_range(0, 9) < 7),
               ($urandom_range(0, 7) != 0) ^ (t >= 200),
               int'($urandom_range(0, 15)),
               1);
      end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
